text_cursor_writer: RTL and testbench

//  Byte-stream-to-text-RAM writer: consumes bytes (e.g. UART RX), writes printable chars at a
//  (row,col) cursor into the text RAM write port and interprets LF/CR/BS/FF control codes.

---
 rtl/text_cursor_if.sv | 27 ++
 rtl/text_cursor_writer.sv | 153 +++++++++++++++
 tb/tb_text_cursor_writer.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_cursor_if.sv
// Byte-in / text-RAM-write-out bus of the text cursor writer.
// master: the writer itself; slave: the byte source, RAM and display side.
interface text_cursor_if #(
  parameter int ROW_W = 2,
  parameter int COL_W = 5
);
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             wr_en;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;
  logic [7:0]       wr_data;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;
  logic             busy;

  modport master (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_row, wr_col, wr_data, cur_row, cur_col, busy
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_row, wr_col, wr_data, cur_row, cur_col, busy
  );
endinterface

// File: rtl/text_cursor_writer.sv
// Writes printable bytes at a (row,col) cursor into a text RAM and interprets
// LF/CR/BS/FF; row entry and form feed run multi-cycle blanking sequences.
module text_cursor_writer #(
  parameter int         COLS            = 32,
  parameter int         ROWS            = 4,
  parameter bit         CLEAR_ON_NEWROW = 1'b1,
  parameter logic [7:0] BLANK           = 8'h20,
  localparam int        COL_W           = $clog2(COLS),
  localparam int        ROW_W           = $clog2(ROWS)
) (
  input logic          clk,
  input logic          reset,
  text_cursor_if.master bus
);

  typedef enum logic [1:0] {IDLE, CLR_ROW, CLR_ALL} state_t;

  state_t           state;
  logic [ROW_W-1:0] clr_row;
  logic [COL_W-1:0] clr_col;

  logic             take;
  logic             printable;
  logic             last_col;
  logic             last_row;
  logic             clr_last_col;
  logic             clr_last_row;
  logic [ROW_W-1:0] next_row;

  assign take         = bus.in_valid & bus.in_ready;
  assign printable    = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E);
  // Wrap points are COLS-1 / ROWS-1, so non-power-of-two geometries work.
  assign last_col     = (bus.cur_col == COL_W'(COLS - 1));
  assign last_row     = (bus.cur_row == ROW_W'(ROWS - 1));
  assign clr_last_col = (clr_col == COL_W'(COLS - 1));
  assign clr_last_row = (clr_row == ROW_W'(ROWS - 1));
  assign next_row     = last_row ? '0 : bus.cur_row + 1'b1;

  // NOTE: every register here is state, so only non-blocking assignments are
  // used; blocking ones would let later statements see half-updated values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      clr_row     <= '0;
      clr_col     <= '0;
      bus.cur_row <= '0;
      bus.cur_col <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_row  <= '0;
      bus.wr_col  <= '0;
      bus.wr_data <= '0;
      bus.in_ready <= 1'b1;
      bus.busy    <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            if (printable) begin
              bus.wr_en   <= 1'b1;
              bus.wr_row  <= bus.cur_row;
              bus.wr_col  <= bus.cur_col;
              bus.wr_data <= bus.in_data;
              if (!last_col) begin
                bus.cur_col <= bus.cur_col + 1'b1;
              end else begin
                bus.cur_col <= '0;
                bus.cur_row <= next_row;
                if (CLEAR_ON_NEWROW) begin
                  state        <= CLR_ROW;
                  clr_col      <= '0;
                  bus.in_ready <= 1'b0;
                  bus.busy     <= 1'b1;
                end
              end
            end else begin
              case (bus.in_data)
                8'h0A: begin
                  bus.cur_col <= '0;
                  bus.cur_row <= next_row;
                  if (CLEAR_ON_NEWROW) begin
                    state        <= CLR_ROW;
                    clr_col      <= '0;
                    bus.in_ready <= 1'b0;
                    bus.busy     <= 1'b1;
                  end
                end
                8'h0D: bus.cur_col <= '0;
                8'h08: begin
                  // Backspace never crosses back into the previous row.
                  if (bus.cur_col != '0) begin
                    bus.cur_col <= bus.cur_col - 1'b1;
                    bus.wr_en   <= 1'b1;
                    bus.wr_row  <= bus.cur_row;
                    bus.wr_col  <= bus.cur_col - 1'b1;
                    bus.wr_data <= BLANK;
                  end
                end
                8'h0C: begin
                  bus.cur_row  <= '0;
                  bus.cur_col  <= '0;
                  state        <= CLR_ALL;
                  clr_row      <= '0;
                  clr_col      <= '0;
                  bus.in_ready <= 1'b0;
                  bus.busy     <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end

        CLR_ROW: begin
          // The cursor already sits on the row being blanked.
          bus.wr_en   <= 1'b1;
          bus.wr_row  <= bus.cur_row;
          bus.wr_col  <= clr_col;
          bus.wr_data <= BLANK;
          if (clr_last_col) begin
            state        <= IDLE;
            bus.in_ready <= 1'b1;
            bus.busy     <= 1'b0;
          end else begin
            clr_col <= clr_col + 1'b1;
          end
        end

        CLR_ALL: begin
          bus.wr_en   <= 1'b1;
          bus.wr_row  <= clr_row;
          bus.wr_col  <= clr_col;
          bus.wr_data <= BLANK;
          if (clr_last_col) begin
            clr_col <= '0;
            if (clr_last_row) begin
              state        <= IDLE;
              bus.in_ready <= 1'b1;
              bus.busy     <= 1'b0;
            end else begin
              clr_row <= clr_row + 1'b1;
            end
          end else begin
            clr_col <= clr_col + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_cursor_writer.sv
// Bench for text_cursor_writer: directed table, corner-case sequences, and
// random bytes against a screen-level reference model (32x4 plus a 20x3 build).
module tb_text_cursor_writer;

  localparam int COLS   = 32;
  localparam int ROWS   = 4;
  localparam int CW     = $clog2(COLS);
  localparam int RW     = $clog2(ROWS);
  localparam int COLS_B = 20;
  localparam int ROWS_B = 3;
  localparam int CWB    = $clog2(COLS_B);
  localparam int RWB    = $clog2(ROWS_B);

  typedef struct {
    int row;
    int col;
    int data;
  } wr_t;

  typedef struct {
    logic [7:0] b;
    int row;
    int col;
    int nwr;
    int w_row;
    int w_col;
    int w_data;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  text_cursor_if #(.ROW_W(RW),  .COL_W(CW))  bus ();
  text_cursor_if #(.ROW_W(RWB), .COL_W(CWB)) bus_b ();

  text_cursor_writer #(.COLS(COLS), .ROWS(ROWS), .CLEAR_ON_NEWROW(1'b1), .BLANK(8'h20))
    dut (.clk(clk), .reset(reset), .bus(bus));

  text_cursor_writer #(.COLS(COLS_B), .ROWS(ROWS_B), .CLEAR_ON_NEWROW(1'b1), .BLANK(8'h20))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  int  vectors = 0;
  int  miscompares = 0;
  wr_t obs[$];
  wr_t obs_b[$];
  wr_t exp_q[$];
  int  mr, mc;
  int  bc;

  always @(negedge clk) begin
    if (!reset && bus.wr_en)   obs.push_back('{int'(bus.wr_row), int'(bus.wr_col), int'(bus.wr_data)});
    if (!reset && bus_b.wr_en) obs_b.push_back('{int'(bus_b.wr_row), int'(bus_b.wr_col), int'(bus_b.wr_data)});
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pk(input int r, input int c, input int d);
    return r * 65536 + c * 256 + d;
  endfunction

  function automatic int obs_at(input int i);
    if (i < obs.size()) return pk(obs[i].row, obs[i].col, obs[i].data);
    return -1;
  endfunction

  function automatic int obs_b_at(input int i);
    if (i < obs_b.size()) return pk(obs_b[i].row, obs_b[i].col, obs_b[i].data);
    return -1;
  endfunction

  function automatic logic [31:0] cur_a();
    return {16'(bus.cur_row), 16'(bus.cur_col)};
  endfunction

  function automatic logic [31:0] cur_b();
    return {16'(bus_b.cur_row), 16'(bus_b.cur_col)};
  endfunction

  // All driving tasks start and end just after a falling edge.
  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    obs.delete();
    obs_b.delete();
    exp_q.delete();
    mr = 0;
    mc = 0;
  endtask

  task automatic send(input logic [7:0] b, output int busy_cycles);
    int n = 0;
    busy_cycles = 0;
    while (!bus.in_ready && n < 300) begin @(negedge clk); n++; end
    if (!bus.in_ready) check("ready_timeout", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.in_ready && busy_cycles < 300) begin busy_cycles++; @(negedge clk); end
    if (!bus.in_ready) check("busy_timeout", 32'(bus.in_ready), 1);
    @(negedge clk);
  endtask

  task automatic send_b(input logic [7:0] b);
    int n = 0;
    while (!bus_b.in_ready && n < 300) begin @(negedge clk); n++; end
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = b;
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    n = 0;
    while (!bus_b.in_ready && n < 300) begin n++; @(negedge clk); end
    if (!bus_b.in_ready) check("b_busy_timeout", 32'(bus_b.in_ready), 1);
    @(negedge clk);
  endtask

  // Screen-level model: cursor as a linear cell position, clears as lists of cells.
  task automatic m_clear_row(input int r);
    for (int c = 0; c < COLS; c++) exp_q.push_back('{r, c, 32'h20});
  endtask

  task automatic model_apply(input logic [7:0] b);
    int pos;
    bit new_row;
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back('{mr, mc, int'(b)});
      new_row = (mc == COLS - 1);
      pos = (mr * COLS + mc + 1) % (ROWS * COLS);
      mr = pos / COLS;
      mc = pos % COLS;
      if (new_row) m_clear_row(mr);
    end else if (b == 8'h0A) begin
      mr = (mr + 1) % ROWS;
      mc = 0;
      m_clear_row(mr);
    end else if (b == 8'h0D) begin
      mc = 0;
    end else if (b == 8'h08) begin
      if (mc > 0) begin
        mc--;
        exp_q.push_back('{mr, mc, 32'h20});
      end
    end else if (b == 8'h0C) begin
      mr = 0;
      mc = 0;
      for (int r = 0; r < ROWS; r++) m_clear_row(r);
    end
  endtask

  task automatic compare_model();
    check("rnd_nwr", obs.size(), exp_q.size());
    foreach (exp_q[i]) check("rnd_wr", obs_at(i), pk(exp_q[i].row, exp_q[i].col, exp_q[i].data));
    check("rnd_cursor", cur_a(), mr * 65536 + mc);
    obs.delete();
    exp_q.delete();
  endtask

  vec_t tbl[18];

  initial begin
    tbl[0]  = '{8'h41, 0, 1, 1,   0, 0, 8'h41};
    tbl[1]  = '{8'h0D, 0, 0, 0,   0, 0, 0};
    tbl[2]  = '{8'h07, 0, 0, 0,   0, 0, 0};
    tbl[3]  = '{8'h9F, 0, 0, 0,   0, 0, 0};
    tbl[4]  = '{8'h42, 0, 1, 1,   0, 0, 8'h42};
    tbl[5]  = '{8'h43, 0, 2, 1,   0, 1, 8'h43};
    tbl[6]  = '{8'h08, 0, 1, 1,   0, 1, 8'h20};
    tbl[7]  = '{8'h08, 0, 0, 1,   0, 0, 8'h20};
    tbl[8]  = '{8'h08, 0, 0, 0,   0, 0, 0};
    tbl[9]  = '{8'h0A, 1, 0, 32,  1, 0, 8'h20};
    tbl[10] = '{8'h78, 1, 1, 1,   1, 0, 8'h78};
    tbl[11] = '{8'h0A, 2, 0, 32,  2, 0, 8'h20};
    tbl[12] = '{8'h0A, 3, 0, 32,  3, 0, 8'h20};
    tbl[13] = '{8'h0A, 0, 0, 32,  0, 0, 8'h20};
    tbl[14] = '{8'h0C, 0, 0, 128, 0, 0, 8'h20};
    tbl[15] = '{8'h7F, 0, 0, 0,   0, 0, 0};
    tbl[16] = '{8'h7E, 0, 1, 1,   0, 0, 8'h7E};
    tbl[17] = '{8'h20, 0, 2, 1,   0, 1, 8'h20};

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus_b.in_valid = 1'b0;
    bus_b.in_data  = 8'h00;

    // Reset state, both while held and just after release.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_wr_bus", 32'({bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_data}), 0);
    check("rst_cursor", cur_a(), 0);
    check("rst_ready_busy", 32'({bus.in_ready, bus.busy}), 2);
    do_reset();
    check("rst_release_ready", 32'({bus.in_ready, bus.busy, bus.wr_en}), 4);

    // Directed table from reset.
    foreach (tbl[i]) begin
      send(tbl[i].b, bc);
      check("tbl_nwr", obs.size(), tbl[i].nwr);
      if (tbl[i].nwr > 0) check("tbl_first_wr", obs_at(0), pk(tbl[i].w_row, tbl[i].w_col, tbl[i].w_data));
      check("tbl_cursor", cur_a(), tbl[i].row * 65536 + tbl[i].col);
      obs.delete();
    end

    // Full row of printables from (1,0): last char at (1,31), then row 2 blanked.
    do_reset();
    send(8'h0A, bc);
    obs.delete();
    for (int i = 0; i < COLS; i++) send(8'h61 + 8'(i % 26), bc);
    check("row_fill_nwr", obs.size(), 64);
    check("row_fill_last_char", obs_at(31), pk(1, 31, 8'h61 + (31 % 26)));
    check("row_fill_first_blank", obs_at(32), pk(2, 0, 8'h20));
    check("row_fill_last_blank", obs_at(63), pk(2, 31, 8'h20));
    check("row_fill_busy_cycles", bc, 32);
    check("row_fill_cursor", cur_a(), 2 * 65536 + 0);

    // LF on the bottom row wraps to the top and clears row 0; CR writes nothing.
    send(8'h0A, bc);
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i), bc);
    check("pre_lf_cursor", cur_a(), 3 * 65536 + 5);
    obs.delete();
    send(8'h0A, bc);
    check("lf_wrap_nwr", obs.size(), 32);
    check("lf_wrap_first", obs_at(0), pk(0, 0, 8'h20));
    check("lf_wrap_last", obs_at(31), pk(0, 31, 8'h20));
    check("lf_wrap_cursor", cur_a(), 0);
    send(8'h0A, bc);
    send(8'h0A, bc);
    for (int i = 0; i < 7; i++) send(8'h41, bc);
    obs.delete();
    send(8'h0D, bc);
    check("cr_nwr", obs.size(), 0);
    check("cr_cursor", cur_a(), 2 * 65536 + 0);

    // Backspace mid-row and at column 0.
    do_reset();
    send(8'h0A, bc);
    for (int i = 0; i < 3; i++) send(8'h58, bc);
    obs.delete();
    send(8'h08, bc);
    check("bs_nwr", obs.size(), 1);
    check("bs_wr", obs_at(0), pk(1, 2, 8'h20));
    check("bs_cursor", cur_a(), 1 * 65536 + 2);
    send(8'h0D, bc);
    obs.delete();
    send(8'h08, bc);
    check("bs_col0_nwr", obs.size(), 0);
    check("bs_col0_cursor", cur_a(), 1 * 65536 + 0);

    // A byte held valid across a row clear is taken once the clear ends.
    obs.delete();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h0A;
    @(negedge clk);
    bus.in_data = 8'h4B;
    bc = 0;
    while (!bus.in_ready && bc < 300) begin bc++; @(negedge clk); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("hold_nwr", obs.size(), 33);
    check("hold_char", obs_at(32), pk(2, 0, 8'h4B));
    check("hold_cursor", cur_a(), 2 * 65536 + 1);

    // Form feed from (2,9): every cell blanked in row-major order.
    do_reset();
    send(8'h0A, bc);
    send(8'h0A, bc);
    for (int i = 0; i < 9; i++) send(8'h2A, bc);
    check("pre_ff_cursor", cur_a(), 2 * 65536 + 9);
    obs.delete();
    send(8'h0C, bc);
    check("ff_nwr", obs.size(), ROWS * COLS);
    begin
      int bad = 0;
      for (int i = 0; i < ROWS * COLS; i++)
        if (obs_at(i) != pk(i / COLS, i % COLS, 8'h20)) bad++;
      check("ff_order_bad_cells", bad, 0);
    end
    check("ff_busy_cycles", bc, ROWS * COLS);
    check("ff_cursor", cur_a(), 0);
    obs.delete();
    send(8'h07, bc);
    send(8'h9F, bc);
    check("drop_nwr", obs.size(), 0);
    check("drop_cursor", cur_a(), 0);

    // Reset in the middle of a form-feed clear.
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h0C;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (39) @(negedge clk);
    check("mid_clear_active", 32'({bus.wr_en, bus.in_ready}), 2);
    #2 reset = 1'b1;
    #1;
    check("mid_clear_wr_en", 32'(bus.wr_en), 0);
    check("mid_clear_cursor", cur_a(), 0);
    check("mid_clear_ready_busy", 32'({bus.in_ready, bus.busy}), 2);
    @(negedge clk);
    reset = 1'b0;
    obs.delete();
    repeat (20) @(negedge clk);
    check("post_abort_nwr", obs.size(), 0);
    check("post_abort_ready", 32'(bus.in_ready), 1);

    // 20x3 build: a char at (2,19) wraps the cursor to (0,0) and clears row 0.
    do_reset();
    send_b(8'h0A);
    send_b(8'h0A);
    for (int i = 0; i < COLS_B - 1; i++) send_b(8'h71);
    check("b_pre_cursor", cur_b(), 2 * 65536 + 19);
    obs_b.delete();
    send_b(8'h5A);
    check("b_nwr", obs_b.size(), COLS_B + 1);
    check("b_char_wr", obs_b_at(0), pk(2, 19, 8'h5A));
    check("b_first_blank", obs_b_at(1), pk(0, 0, 8'h20));
    check("b_last_blank", obs_b_at(COLS_B), pk(0, COLS_B - 1, 8'h20));
    check("b_cursor", cur_b(), 0);

    // Random byte stream against the model.
    do_reset();
    for (int n = 0; n < 200; n++) begin
      int r;
      logic [7:0] b;
      r = int'($urandom_range(0, 99));
      if (r < 60)      b = 8'($urandom_range(8'h20, 8'h7E));
      else if (r < 70) b = 8'h0A;
      else if (r < 78) b = 8'h0D;
      else if (r < 90) b = 8'h08;
      else if (r < 92) b = 8'h0C;
      else             b = 8'($urandom_range(0, 255));
      model_apply(b);
      send(b, bc);
      compare_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
